// File: rtl/uart_ram_pkg.sv
// Shared types and constants for the UART command sequencer.
// The command byte carries the read/write flag and the length-minus-one field.
package uart_ram_pkg;

    localparam int CMD_RD_BIT = 7;
    localparam int CMD_LEN_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RREQ  = 3'd3,
        S_RWAIT = 3'd4,
        S_RSEND = 3'd5
    } cmd_state_t;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Parses a UART byte stream into RAM read/write bursts and streams read bytes
// back to the transmitter; receiver inactivity aborts a partial frame.
module uart_cmd_ctrl
    import uart_ram_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int ADDR_BYTES = 2,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_inactive,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_err
);

    localparam int AB_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    cmd_state_t           state_q, state_d;
    logic                 rw_q, rw_d;
    logic [CMD_LEN_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [AB_W-1:0]      abyte_q, abyte_d;
    logic [1:0]           lat_q, lat_d;
    logic                 ram_we_q, ram_we_d;
    logic                 ram_re_q, ram_re_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [7:0]           ram_wdata_q, ram_wdata_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic [ADDR_W+7:0]    addr_shift;

    // Address bytes arrive MSB first; only the low ADDR_W bits survive.
    assign addr_shift = {addr_q, rx_data};

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        abyte_d     = abyte_q;
        lat_d       = lat_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    rw_d    = rx_data[CMD_RD_BIT];
                    cnt_d   = rx_data[CMD_LEN_W-1:0];
                    abyte_d = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d  = addr_shift[ADDR_W-1:0];
                    abyte_d = abyte_q + AB_W'(1);
                    if (abyte_q == AB_W'(ADDR_BYTES - 1)) begin
                        state_d = rw_q ? S_RREQ : S_WDATA;
                    end
                end else if (rx_inactive) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    ram_we_d    = 1'b1;
                    ram_wdata_d = rx_data;
                    ram_addr_d  = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - CMD_LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end
                end else if (rx_inactive) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_RREQ: begin
                ram_re_d   = 1'b1;
                ram_addr_d = addr_q;
                lat_d      = '0;
                state_d    = S_RWAIT;
            end
            S_RWAIT: begin
                // lat_q counts cycles since the strobe; data is valid at RD_LAT.
                if (lat_q == 2'(RD_LAT)) begin
                    tx_data_d  = ram_rdata;
                    tx_valid_d = 1'b1;
                    state_d    = S_RSEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_RSEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q - CMD_LEN_W'(1);
                    state_d    = (cnt_q == '0) ? S_IDLE : S_RREQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bytes arriving while a read is in flight are discarded.
        if ((state_q == S_RREQ || state_q == S_RWAIT || state_q == S_RSEND) && rx_valid) begin
            frame_err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rw_q        <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            abyte_q     <= '0;
            lat_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            abyte_q     <= abyte_d;
            lat_q       <= lat_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
